la_capture_engine: RTL and testbench
====================================

# la_capture_engine

Parametrised logic-analyser capture core that succeeds the fixed 9-channel shift-register capture. It records `pCHANNELS` signals into a `pDEPTH`-entry circular block-RAM buffer and adds a programmable pre-trigger window, trigger edge/level modes, downsampling, abort and logically ordered readout. It runs entirely in the observer clock domain; register-side CDC is handled outside the block.

## Interface
- `pCHANNELS`, 9: number of captured channels.
- `pDEPTH`, 1024: samples per capture; must be a power of two, ≥ 4.
- `pADDR_BITS`, 10: log2(`pDEPTH`).
- `observer_clk` in 1: sample clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `sample_data` in `pCHANNELS`: channels sampled each enabled cycle.
- `trigger_in` in 1: trigger source, already synchronised.
- `arm` in 1: single-cycle start pulse.
- `abort` in 1: single-cycle cancel pulse.
- `cfg_pretrig` in `pADDR_BITS`+1: requested pre-trigger sample count.
- `cfg_downsample` in 16: write one sample every N+1 cycles.
- `cfg_trig_mode` in 2: 0 rising, 1 falling, 2 level high, 3 level low.
- `rd_en` in 1: readout strobe.
- `rd_index` in `pADDR_BITS`: logical index; 0 is the oldest sample.
- `rd_data` out `pCHANNELS`: readout data.
- `capturing` out 1: high in PRETRIG, WAIT_TRIG and POST.
- `triggered` out 1: high in POST and DONE.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, PRETRIG, WAIT_TRIG, POST, DONE.
- `arm` in IDLE or DONE latches the configuration and clears `wr_ptr`, the downsample counter and the sample counters.
  - Next state is PRETRIG, or WAIT_TRIG if the latched pretrig is 0.
  - `arm` in any other state is ignored.
- Latched pretrig = min(`cfg_pretrig`, `pDEPTH`-1). Config input changes after arm have no effect.
- Sample enable: downsample counter `ds_cnt` counts 0..N and wraps. A write occurs when `ds_cnt`==0. Each write stores `sample_data` at `wr_ptr`, then `wr_ptr` increments mod `pDEPTH`.
- PRETRIG: performs the latched-pretrig number of writes; the trigger is ignored. Moves to WAIT_TRIG on the last pretrig write.
- WAIT_TRIG: writes continue circularly. The trigger is evaluated every cycle, not only on enabled cycles.
  - Rising edge = `trigger_in` & ~`trig_prev`. Falling edge is the inverse. Level modes test `trigger_in` directly.
  - `trig_prev` is registered every cycle in all states. It is cleared on arm, so a trigger already high at arm counts as a rising edge.
- Trigger cycle:
  - The sample is written unconditionally and `ds_cnt` is forced to 1.
  - `start_ptr` = `wr_ptr` − pretrig (mod `pDEPTH`), computed from the pre-increment `wr_ptr`.
  - The state moves to POST. Post-remaining = `pDEPTH` − pretrig − 1.
- POST: decrements post-remaining on each write. Moves to DONE on the write that reaches 0, or immediately if it is already 0.
- DONE: holds the buffer. `arm` restarts capture.
- `abort` in any state goes to IDLE; the buffer contents are retained but invalid. Simultaneous `abort`+`arm` → abort wins, state IDLE.
- Readout: physical address = `start_ptr` + `rd_index` mod `pDEPTH`. Data is meaningful only in DONE; outside DONE, the contents are unspecified but no hazard occurs.
- Buffer contents are not cleared by reset.

## Timing
- Reset: state IDLE; `capturing`=`triggered`=`done`=0; `rd_data`=0; `wr_ptr`=`start_ptr`=0; `ds_cnt`=0; `trig_prev`=0.
- Arm at cycle T → `capturing`=1 at T+1. The first write happens at T+1 (`ds_cnt`=0).
- Trigger at cycle T → `triggered`=1 at T+1. The trigger sample is the `sample_data` present at cycle T.
- Final POST write at cycle T → `capturing`=0 and `done`=1 at T+1.
- `rd_en` at cycle T → `rd_data` valid at T+1, holding the value until the next `rd_en`. This gives one read per cycle, fully pipelined.
- Status outputs are registered and decoded from state.

## Test plan
- `pDEPTH`=16, `pCHANNELS`=4, `sample_data` = free-running 4-bit counter, pretrig=4, downsample=0, rising mode; edge arrives when the counter reads 9 → `done`, then index 0..3 = 5,6,7,8; index 4 = 9; indices 5..15 = A..F,0..4.
- Level-high mode, `trigger_in` held high, pretrig=0 → `triggered` one cycle after `capturing`; index 0 = counter value at the arm+1 cycle; `done` 16 cycles after arm+1.
- downsample=2, pretrig=2; trigger asserted one cycle after an enabled write → trigger sample written immediately; next writes 3 cycles apart; index 2 = counter at trigger; indices 1 and 0 = trigger-cycle counter −1 and −4.
- `cfg_pretrig`=20 → clamped to 15; index 15 = trigger sample; exactly 15 pretrig writes before WAIT_TRIG.
- Abort in POST → IDLE next cycle, `done`=0, `triggered`=0. Re-arm completes a normal capture. `arm`+`abort` in the same cycle → stays IDLE.
- Reset asserted mid-WAIT_TRIG → next cycle all outputs 0, state IDLE. Trigger edges ignored until the next arm.

Source files
------------

// File: rtl/la_capture_engine_if.sv
// Control, configuration, status and readout signals of the logic-analyser capture core.
interface la_capture_engine_if #(
  parameter int unsigned pCHANNELS  = 9,
  parameter int unsigned pADDR_BITS = 10
);
  logic [pCHANNELS-1:0]  sample_data;
  logic                  trigger_in;
  logic                  arm;
  logic                  abort;
  logic [pADDR_BITS:0]   cfg_pretrig;
  logic [15:0]           cfg_downsample;
  logic [1:0]            cfg_trig_mode;
  logic                  rd_en;
  logic [pADDR_BITS-1:0] rd_index;
  logic [pCHANNELS-1:0]  rd_data;
  logic                  capturing;
  logic                  triggered;
  logic                  done;

  modport master (
    output sample_data, trigger_in, arm, abort, cfg_pretrig, cfg_downsample, cfg_trig_mode,
           rd_en, rd_index,
    input  rd_data, capturing, triggered, done
  );

  modport slave (
    input  sample_data, trigger_in, arm, abort, cfg_pretrig, cfg_downsample, cfg_trig_mode,
           rd_en, rd_index,
    output rd_data, capturing, triggered, done
  );
endinterface

// File: rtl/la_capture_engine.sv
// Logic-analyser capture core: circular sample buffer with pre-trigger window, trigger
// modes, downsampling, abort and readout ordered from the oldest sample.
module la_capture_engine #(
  parameter int unsigned pCHANNELS  = 9,
  parameter int unsigned pDEPTH     = 1024,
  parameter int unsigned pADDR_BITS = 10
) (
  input logic                observer_clk,
  input logic                reset,
  la_capture_engine_if.slave bus
);
  typedef enum logic [2:0] {StIdle, StPretrig, StWaitTrig, StPost, StDone} state_e;
  typedef logic [pADDR_BITS-1:0] addr_t;

  localparam addr_t               MaxPretrig  = addr_t'(pDEPTH - 1);
  localparam logic [pADDR_BITS:0] MaxPretrigW = (pADDR_BITS + 1)'(pDEPTH - 1);

  state_e               state_q, state_d;
  addr_t                wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d;
  addr_t                pre_rem_q, pre_rem_d, post_rem_q, post_rem_d, pretrig_q, pretrig_d;
  logic [15:0]          ds_cnt_q, ds_cnt_d, downsample_q, downsample_d, ds_next;
  logic [1:0]           mode_q, mode_d;
  logic                 trig_prev_q, trig_prev_d;
  logic                 capturing_q, triggered_q, done_q;
  logic [pCHANNELS-1:0] rd_data_q;
  logic [pCHANNELS-1:0] mem [pDEPTH];
  logic                 wr_en, trig_hit, ds_zero;
  addr_t                cfg_clamped, rd_addr;

  assign cfg_clamped = (bus.cfg_pretrig > MaxPretrigW) ? MaxPretrig
                                                       : addr_t'(bus.cfg_pretrig);
  assign ds_zero     = (ds_cnt_q == '0);
  assign ds_next     = (ds_cnt_q >= downsample_q) ? '0 : ds_cnt_q + 16'd1;
  assign rd_addr     = start_ptr_q + bus.rd_index;

  always_comb begin
    trig_hit = 1'b0;
    unique case (mode_q)
      2'd0:    trig_hit = bus.trigger_in & ~trig_prev_q;
      2'd1:    trig_hit = ~bus.trigger_in & trig_prev_q;
      2'd2:    trig_hit = bus.trigger_in;
      default: trig_hit = ~bus.trigger_in;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    start_ptr_d  = start_ptr_q;
    pre_rem_d    = pre_rem_q;
    post_rem_d   = post_rem_q;
    pretrig_d    = pretrig_q;
    ds_cnt_d     = ds_cnt_q;
    downsample_d = downsample_q;
    mode_d       = mode_q;
    trig_prev_d  = bus.trigger_in;
    wr_en        = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.arm) begin
            pretrig_d    = cfg_clamped;
            downsample_d = bus.cfg_downsample;
            mode_d       = bus.cfg_trig_mode;
            wr_ptr_d     = '0;
            ds_cnt_d     = '0;
            pre_rem_d    = cfg_clamped;
            post_rem_d   = '0;
            trig_prev_d  = 1'b0;
            state_d      = (cfg_clamped == '0) ? StWaitTrig : StPretrig;
          end
        end
        StPretrig: begin
          ds_cnt_d = ds_next;
          wr_en    = ds_zero;
          if (ds_zero) begin
            pre_rem_d = pre_rem_q - addr_t'(1);
            if (pre_rem_q == addr_t'(1)) state_d = StWaitTrig;
          end
        end
        StWaitTrig: begin
          ds_cnt_d = ds_next;
          wr_en    = ds_zero;
          if (trig_hit) begin
            // Trigger sample is always stored; the downsample phase restarts from it.
            wr_en       = 1'b1;
            ds_cnt_d    = (downsample_q == '0) ? '0 : 16'd1;
            start_ptr_d = wr_ptr_q - pretrig_q;
            post_rem_d  = MaxPretrig - pretrig_q;
            state_d     = StPost;
          end
        end
        StPost: begin
          ds_cnt_d = ds_next;
          if (post_rem_q == '0) begin
            state_d = StDone;
          end else if (ds_zero) begin
            wr_en      = 1'b1;
            post_rem_d = post_rem_q - addr_t'(1);
            if (post_rem_q == addr_t'(1)) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + addr_t'(1);
  end

  always_ff @(posedge observer_clk) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      start_ptr_q  <= '0;
      pre_rem_q    <= '0;
      post_rem_q   <= '0;
      pretrig_q    <= '0;
      ds_cnt_q     <= '0;
      downsample_q <= '0;
      mode_q       <= '0;
      trig_prev_q  <= 1'b0;
      capturing_q  <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_ptr_q  <= start_ptr_d;
      pre_rem_q    <= pre_rem_d;
      post_rem_q   <= post_rem_d;
      pretrig_q    <= pretrig_d;
      ds_cnt_q     <= ds_cnt_d;
      downsample_q <= downsample_d;
      mode_q       <= mode_d;
      trig_prev_q  <= trig_prev_d;
      capturing_q  <= state_d inside {StPretrig, StWaitTrig, StPost};
      triggered_q  <= state_d inside {StPost, StDone};
      done_q       <= (state_d == StDone);
    end
  end

  // Buffer has no reset so it maps onto block RAM.
  always_ff @(posedge observer_clk) begin
    if (wr_en && !reset) mem[wr_ptr_q] <= bus.sample_data;
  end

  always_ff @(posedge observer_clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (bus.rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.capturing = capturing_q;
  assign bus.triggered = triggered_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_la_capture_engine.sv
// Self-checking bench for la_capture_engine: expected buffer contents are queued when the
// trigger is driven and compared as the logically ordered readout returns them.
module tb_la_capture_engine;
  localparam int unsigned Ch    = 4;
  localparam int unsigned Depth = 16;
  localparam int unsigned Aw    = 4;

  logic       observer_clk = 1'b0;
  logic       reset;
  logic [3:0] cnt = 4'd0;
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  la_capture_engine_if #(.pCHANNELS(Ch), .pADDR_BITS(Aw)) bus ();

  la_capture_engine #(
    .pCHANNELS (Ch),
    .pDEPTH    (Depth),
    .pADDR_BITS(Aw)
  ) dut (
    .observer_clk(observer_clk),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 observer_clk = ~observer_clk;
  always @(posedge observer_clk) cnt <= cnt + 4'd1;
  assign bus.sample_data = cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge observer_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Config is scrambled right after arm to show it was latched.
  task automatic arm_capture(input logic [4:0] pre, input logic [15:0] ds, input logic [1:0] mode);
    bus.cfg_pretrig    = pre;
    bus.cfg_downsample = ds;
    bus.cfg_trig_mode  = mode;
    bus.arm            = 1'b1;
    tick();
    bus.arm            = 1'b0;
    bus.cfg_pretrig    = 5'd1;
    bus.cfg_downsample = 16'd7;
    bus.cfg_trig_mode  = ~mode;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (!bus.done && k < limit) begin
      tick();
      k++;
    end
    check_eq(tag, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic read_all(input string tag);
    logic [3:0] exp = 4'd0;
    for (int i = 0; i < Depth; i++) begin
      bus.rd_en    = 1'b1;
      bus.rd_index = 4'(i);
      tick();
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      check_eq($sformatf("%s_rd[%0d]", tag, i), {28'd0, bus.rd_data}, {28'd0, exp});
    end
    bus.rd_en    = 1'b0;
    bus.rd_index = 4'd0;
    tick();
    check_eq({tag, "_rd_hold"}, {28'd0, bus.rd_data}, {28'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] c;
    reset              = 1'b1;
    bus.trigger_in     = 1'b0;
    bus.arm            = 1'b0;
    bus.abort          = 1'b0;
    bus.cfg_pretrig    = '0;
    bus.cfg_downsample = '0;
    bus.cfg_trig_mode  = '0;
    bus.rd_en          = 1'b0;
    bus.rd_index       = '0;
    ticks(3);
    check_eq("reset_capturing", {31'd0, bus.capturing}, 32'd0);
    check_eq("reset_triggered", {31'd0, bus.triggered}, 32'd0);
    check_eq("reset_done", {31'd0, bus.done}, 32'd0);
    check_eq("reset_rd_data", {28'd0, bus.rd_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Rising edge while the counter reads 9, pretrig 4.
    arm_capture(5'd4, 16'd0, 2'd0);
    check_eq("t1_capturing", {31'd0, bus.capturing}, 32'd1);
    ticks(5);
    while (cnt != 4'd9) tick();
    c = cnt;
    bus.trigger_in = 1'b1;
    for (int i = 0; i < Depth; i++) exp_q.push_back(4'(c - 4'd4 + 4'(i)));
    tick();
    bus.trigger_in = 1'b0;
    check_eq("t1_triggered", {31'd0, bus.triggered}, 32'd1);
    wait_done("t1_done", 40);
    read_all("t1");

    // Level high already asserted, pretrig 0.
    bus.trigger_in = 1'b1;
    arm_capture(5'd0, 16'd0, 2'd2);
    check_eq("t2_capturing", {31'd0, bus.capturing}, 32'd1);
    check_eq("t2_not_trig", {31'd0, bus.triggered}, 32'd0);
    c = cnt;
    for (int i = 0; i < Depth; i++) exp_q.push_back(4'(c + 4'(i)));
    tick();
    check_eq("t2_triggered", {31'd0, bus.triggered}, 32'd1);
    ticks(14);
    check_eq("t2_done_early", {31'd0, bus.done}, 32'd0);
    tick();
    check_eq("t2_done", {31'd0, bus.done}, 32'd1);
    bus.trigger_in = 1'b0;
    read_all("t2");

    // Downsample 2, pretrig 2; trigger one cycle after the write at arm+7.
    arm_capture(5'd2, 16'd2, 2'd0);
    ticks(7);
    check_eq("t3_not_trig", {31'd0, bus.triggered}, 32'd0);
    c = cnt;
    bus.trigger_in = 1'b1;
    exp_q.push_back(4'(c - 4'd4));
    exp_q.push_back(4'(c - 4'd1));
    for (int k = 0; k < Depth - 2; k++) exp_q.push_back(4'(c + 4'(3 * k)));
    tick();
    bus.trigger_in = 1'b0;
    check_eq("t3_triggered", {31'd0, bus.triggered}, 32'd1);
    wait_done("t3_done", 60);
    read_all("t3");

    // Pretrig 20 clamps to 15; an edge during the 15th pretrig write is ignored.
    arm_capture(5'd20, 16'd0, 2'd0);
    c = cnt;
    ticks(14);
    bus.trigger_in = 1'b1;
    tick();
    check_eq("t4_early_edge", {31'd0, bus.triggered}, 32'd0);
    bus.trigger_in = 1'b0;
    tick();
    bus.trigger_in = 1'b1;
    for (int i = 0; i < Depth; i++) exp_q.push_back(4'(c + 4'd1 + 4'(i)));
    tick();
    bus.trigger_in = 1'b0;
    check_eq("t4_triggered", {31'd0, bus.triggered}, 32'd1);
    tick();
    check_eq("t4_done", {31'd0, bus.done}, 32'd1);
    read_all("t4");

    // Abort in POST, re-arm, then arm+abort together.
    bus.trigger_in = 1'b1;
    arm_capture(5'd0, 16'd0, 2'd2);
    tick();
    check_eq("t5_in_post", {31'd0, bus.triggered}, 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t5_abort_trig", {31'd0, bus.triggered}, 32'd0);
    check_eq("t5_abort_done", {31'd0, bus.done}, 32'd0);
    check_eq("t5_abort_capt", {31'd0, bus.capturing}, 32'd0);
    arm_capture(5'd0, 16'd0, 2'd2);
    c = cnt;
    for (int i = 0; i < Depth; i++) exp_q.push_back(4'(c + 4'(i)));
    wait_done("t5_rearm_done", 40);
    read_all("t5");
    bus.arm   = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    check_eq("t5_arm_abort_capt", {31'd0, bus.capturing}, 32'd0);
    check_eq("t5_arm_abort_done", {31'd0, bus.done}, 32'd0);
    bus.trigger_in = 1'b0;

    // Reset in WAIT_TRIG, later edges ignored.
    arm_capture(5'd0, 16'd0, 2'd0);
    ticks(3);
    check_eq("t6_capturing", {31'd0, bus.capturing}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_rst_capt", {31'd0, bus.capturing}, 32'd0);
    check_eq("t6_rst_trig", {31'd0, bus.triggered}, 32'd0);
    check_eq("t6_rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("t6_rst_rd_data", {28'd0, bus.rd_data}, 32'd0);
    bus.trigger_in = 1'b1;
    ticks(3);
    check_eq("t6_edge_ignored", {31'd0, bus.triggered}, 32'd0);
    check_eq("t6_still_idle", {31'd0, bus.capturing}, 32'd0);
    bus.trigger_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
